// File: rtl/dmi_pkg.sv
// Shared definitions for the DMI responder: op/resp codes, register map,
// dmcontrol bit positions and the handshake FSM state encoding.
package dmi_pkg;

    typedef enum logic [1:0] {
        DMI_OP_NOP   = 2'd0,
        DMI_OP_READ  = 2'd1,
        DMI_OP_WRITE = 2'd2,
        DMI_OP_RSVD  = 2'd3
    } dmi_op_e;

    localparam logic [1:0] DMI_RESP_OK   = 2'd0;
    localparam logic [1:0] DMI_RESP_FAIL = 2'd2;

    localparam logic [6:0] ADDR_DATA0      = 7'h04;
    localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
    localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
    localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;

    localparam int DMCTRL_DMACTIVE  = 0;
    localparam int DMCTRL_NDMRESET  = 1;
    localparam int DMCTRL_RESUMEREQ = 30;
    localparam int DMCTRL_HALTREQ   = 31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_EXEC,
        ST_RESP
    } dmi_state_e;

endpackage

// File: rtl/dmi_regfile.sv
// Debug-module register set: decode, read mux, write side effects and the
// sticky resumeack flag. Acts only on the cycle the exec strobe is high.
module dmi_regfile
    import dmi_pkg::*;
#(
    parameter int NDATA = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_exec,
    input  logic [6:0]  i_addr,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_wdata,
    input  logic        i_hart_halted,
    input  logic        i_hart_resume_ack,
    output logic [1:0]  o_resp,
    output logic [31:0] o_rdata,
    output logic        o_dm_active,
    output logic        o_halt_req,
    output logic        o_ndm_reset,
    output logic        o_resume_req
);

    logic [31:0]      r_data [NDATA];
    logic             r_dm_active;
    logic             r_halt_req;
    logic             r_ndm_reset;
    logic             r_resume_req;
    logic             r_resumeack;
    logic [1:0]       r_resp;
    logic [31:0]      r_rdata;

    logic [NDATA-1:0] w_hit_data;
    logic             w_mapped;
    logic [31:0]      w_read_val;
    logic [1:0]       w_resp;
    logic [31:0]      w_rdata;
    logic             w_write;
    logic             w_ctrl_write;
    logic             w_ctrl_clear;
    logic             w_ctrl_resume;

    // NOTE: every always_comb output gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        w_hit_data = '0;
        w_mapped   = 1'b0;
        w_read_val = '0;
        for (int i = 0; i < NDATA; i++) begin
            if (i_addr == ADDR_DATA0 + 7'(i)) begin
                w_hit_data[i] = 1'b1;
                w_mapped      = 1'b1;
                w_read_val    = r_data[i];
            end
        end
        case (i_addr)
            ADDR_DMCONTROL: begin
                w_mapped                    = 1'b1;
                w_read_val[DMCTRL_DMACTIVE] = r_dm_active;
                w_read_val[DMCTRL_NDMRESET] = r_ndm_reset;
                w_read_val[DMCTRL_HALTREQ]  = r_halt_req;
            end
            ADDR_DMSTATUS: begin
                w_mapped          = 1'b1;
                w_read_val[3:0]   = 4'd2;
                w_read_val[7]     = 1'b1;
                w_read_val[9:8]   = {2{i_hart_halted}};
                w_read_val[11:10] = {2{r_dm_active & ~i_hart_halted}};
                w_read_val[17:16] = {2{r_resumeack}};
            end
            ADDR_ABSTRACTCS: begin
                w_mapped        = 1'b1;
                w_read_val[3:0] = 4'(NDATA);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_resp  = DMI_RESP_OK;
        w_rdata = '0;
        w_write = 1'b0;
        case (dmi_op_e'(i_op))
            DMI_OP_NOP: ;
            DMI_OP_READ: begin
                if (w_mapped) w_rdata = w_read_val;
                else          w_resp  = DMI_RESP_FAIL;
            end
            DMI_OP_WRITE: begin
                if (w_mapped) w_write = 1'b1;
                else          w_resp  = DMI_RESP_FAIL;
            end
            default: w_resp = DMI_RESP_FAIL;
        endcase
    end

    // A dmcontrol write with dmactive=0 resets the module state instead of updating fields.
    assign w_ctrl_write  = i_exec && w_write && (i_addr == ADDR_DMCONTROL);
    assign w_ctrl_clear  = w_ctrl_write && !i_wdata[DMCTRL_DMACTIVE];
    assign w_ctrl_resume = w_ctrl_write && i_wdata[DMCTRL_DMACTIVE] && i_wdata[DMCTRL_RESUMEREQ];

    // NOTE: state updates use <= so every register samples the pre-edge values.
    // NOTE: the data registers are architectural state and must clear on reset, so the array is reset too.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NDATA; i++) r_data[i] <= '0;
            r_dm_active  <= 1'b0;
            r_halt_req   <= 1'b0;
            r_ndm_reset  <= 1'b0;
            r_resume_req <= 1'b0;
            r_resumeack  <= 1'b0;
            r_resp       <= '0;
            r_rdata      <= '0;
        end else begin
            r_resume_req <= w_ctrl_resume;
            if (i_exec) begin
                r_resp  <= w_resp;
                r_rdata <= w_rdata;
            end
            if (w_ctrl_clear || w_ctrl_resume) r_resumeack <= 1'b0;
            else if (i_hart_resume_ack)        r_resumeack <= 1'b1;
            if (w_ctrl_clear) begin
                r_dm_active <= 1'b0;
                r_halt_req  <= 1'b0;
                r_ndm_reset <= 1'b0;
            end else if (w_ctrl_write) begin
                r_dm_active <= 1'b1;
                r_halt_req  <= i_wdata[DMCTRL_HALTREQ];
                r_ndm_reset <= i_wdata[DMCTRL_NDMRESET];
            end
            for (int i = 0; i < NDATA; i++) begin
                if (w_ctrl_clear)                            r_data[i] <= '0;
                else if (i_exec && w_write && w_hit_data[i]) r_data[i] <= i_wdata;
            end
        end
    end

    assign o_resp       = r_resp;
    assign o_rdata      = r_rdata;
    assign o_dm_active  = r_dm_active;
    assign o_halt_req   = r_halt_req;
    assign o_ndm_reset  = r_ndm_reset;
    assign o_resume_req = r_resume_req;

endmodule

// File: rtl/dmi_responder.sv
// DMI target: accepts one request at a time, waits ACCESS_LATENCY cycles,
// executes it on the register set and holds the response until taken.
module dmi_responder
    import dmi_pkg::*;
#(
    parameter int NDATA          = 2,
    parameter int ACCESS_LATENCY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        debug_req_valid,
    output logic        debug_req_ready,
    input  logic [6:0]  debug_req_bits_addr,
    input  logic [1:0]  debug_req_bits_op,
    input  logic [31:0] debug_req_bits_data,
    output logic        debug_resp_valid,
    input  logic        debug_resp_ready,
    output logic [1:0]  debug_resp_bits_resp,
    output logic [31:0] debug_resp_bits_data,
    input  logic        hart_halted,
    input  logic        hart_resume_ack,
    output logic        dm_active,
    output logic        halt_req,
    output logic        ndm_reset,
    output logic        resume_req
);

    dmi_state_e  r_state;
    dmi_state_e  w_next_state;
    logic [6:0]  r_addr;
    logic [1:0]  r_op;
    logic [31:0] r_wdata;
    logic [3:0]  r_count;

    logic [1:0]  w_resp;
    logic [31:0] w_rdata;
    logic        w_dm_active;
    logic        w_halt_req;
    logic        w_ndm_reset;
    logic        w_resume_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_op    <= '0;
            r_wdata <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && debug_req_valid) begin
                r_addr  <= debug_req_bits_addr;
                r_op    <= debug_req_bits_op;
                r_wdata <= debug_req_bits_data;
                r_count <= 4'(ACCESS_LATENCY - 1);
            end else if (r_state == ST_ACCESS) begin
                r_count <= r_count - 4'd1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (debug_req_valid) w_next_state = (ACCESS_LATENCY > 0) ? ST_ACCESS : ST_EXEC;
            end
            ST_ACCESS: begin
                if (r_count == 4'd0) w_next_state = ST_EXEC;
            end
            ST_EXEC:  w_next_state = ST_RESP;
            ST_RESP: begin
                if (debug_resp_ready) w_next_state = ST_IDLE;
            end
            default:  w_next_state = ST_IDLE;
        endcase
    end

    dmi_regfile #(
        .NDATA(NDATA)
    ) u_regfile (
        .clk              (clk),
        .reset            (reset),
        .i_exec           (r_state == ST_EXEC),
        .i_addr           (r_addr),
        .i_op             (r_op),
        .i_wdata          (r_wdata),
        .i_hart_halted    (hart_halted),
        .i_hart_resume_ack(hart_resume_ack),
        .o_resp           (w_resp),
        .o_rdata          (w_rdata),
        .o_dm_active      (w_dm_active),
        .o_halt_req       (w_halt_req),
        .o_ndm_reset      (w_ndm_reset),
        .o_resume_req     (w_resume_req)
    );

    // Outputs are forced low while reset is held, before the first reset edge lands.
    assign debug_req_ready      = !reset && (r_state == ST_IDLE);
    assign debug_resp_valid     = !reset && (r_state == ST_RESP);
    assign debug_resp_bits_resp = reset ? 2'd0  : w_resp;
    assign debug_resp_bits_data = reset ? 32'd0 : w_rdata;
    assign dm_active            = !reset && w_dm_active;
    assign halt_req             = !reset && w_halt_req;
    assign ndm_reset            = !reset && w_ndm_reset;
    assign resume_req           = !reset && w_resume_req;

endmodule

// File: tb/tb_dmi_responder.sv
// Self-checking bench for dmi_responder: a zero-latency instance and an
// ACCESS_LATENCY=3 instance, checked against a register-level model.
module tb_dmi_responder;

    localparam int NDATA = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic [6:0]  req_addr = '0;
    logic [1:0]  req_op = '0;
    logic [31:0] req_data = '0;
    logic        resp_ready = 1'b0;
    logic        hart_halted = 1'b0;
    logic        hart_resume_ack = 1'b0;

    logic        rdy0, rdy3, rv0, rv3, act0, act3, hlt0, hlt3, ndm0, ndm3, rsm0, rsm3;
    logic [1:0]  rsp0, rsp3;
    logic [31:0] dat0, dat3;

    wire         req_ready  = sel ? rdy3 : rdy0;
    wire         resp_valid = sel ? rv3  : rv0;
    wire [1:0]   resp_bits  = sel ? rsp3 : rsp0;
    wire [31:0]  resp_data  = sel ? dat3 : dat0;
    wire         resume_req = sel ? rsm3 : rsm0;

    int n_compared = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    dmi_responder #(.NDATA(NDATA), .ACCESS_LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .debug_req_valid(req_valid && !sel), .debug_req_ready(rdy0),
        .debug_req_bits_addr(req_addr), .debug_req_bits_op(req_op), .debug_req_bits_data(req_data),
        .debug_resp_valid(rv0), .debug_resp_ready(resp_ready && !sel),
        .debug_resp_bits_resp(rsp0), .debug_resp_bits_data(dat0),
        .hart_halted(hart_halted), .hart_resume_ack(hart_resume_ack),
        .dm_active(act0), .halt_req(hlt0), .ndm_reset(ndm0), .resume_req(rsm0)
    );

    dmi_responder #(.NDATA(NDATA), .ACCESS_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .debug_req_valid(req_valid && sel), .debug_req_ready(rdy3),
        .debug_req_bits_addr(req_addr), .debug_req_bits_op(req_op), .debug_req_bits_data(req_data),
        .debug_resp_valid(rv3), .debug_resp_ready(resp_ready && sel),
        .debug_resp_bits_resp(rsp3), .debug_resp_bits_data(dat3),
        .hart_halted(hart_halted), .hart_resume_ack(hart_resume_ack),
        .dm_active(act3), .halt_req(hlt3), .ndm_reset(ndm3), .resume_req(rsm3)
    );

    // Register-level model of the zero-latency instance.
    logic [31:0] m_data [NDATA];
    logic        m_dmactive, m_haltreq, m_ndmreset, m_resumeack;

    task automatic model_reset();
        for (int i = 0; i < NDATA; i++) m_data[i] = '0;
        m_dmactive = 0; m_haltreq = 0; m_ndmreset = 0; m_resumeack = 0;
    endtask

    task automatic model_txn(input logic [6:0] addr, input logic [1:0] op, input logic [31:0] wdata,
                             output logic [1:0] exp_resp, output logic [31:0] exp_data,
                             output int exp_pulses);
        bit is_data;
        int idx;
        exp_resp = 2'd0; exp_data = '0; exp_pulses = 0;
        idx = int'(addr) - 4;
        is_data = (idx >= 0) && (idx < NDATA);
        if (op == 2'd3) begin
            exp_resp = 2'd2;
        end else if (op == 2'd1) begin
            if (is_data)           exp_data = m_data[idx];
            else if (addr == 7'h10) exp_data = (32'(m_haltreq) << 31) | (32'(m_ndmreset) << 1) | 32'(m_dmactive);
            else if (addr == 7'h11) exp_data = 32'h82 | (hart_halted ? 32'h300 : 32'h0)
                                             | ((m_dmactive && !hart_halted) ? 32'hC00 : 32'h0)
                                             | (m_resumeack ? 32'h30000 : 32'h0);
            else if (addr == 7'h16) exp_data = 32'(NDATA);
            else                    exp_resp = 2'd2;
        end else if (op == 2'd2) begin
            if (is_data) begin
                m_data[idx] = wdata;
            end else if (addr == 7'h10) begin
                if (!wdata[0]) begin
                    model_reset();
                end else begin
                    m_dmactive = 1; m_haltreq = wdata[31]; m_ndmreset = wdata[1];
                    if (wdata[30]) begin
                        m_resumeack = 0;
                        exp_pulses = 1;
                    end
                end
            end else if (addr != 7'h11 && addr != 7'h16) begin
                exp_resp = 2'd2;
            end
        end
    endtask

    // Drives one request on the selected instance; starts and ends at a negedge.
    // lat counts posedges from the accept edge (inclusive) to the first one after which resp_valid is seen.
    task automatic do_txn(input logic [6:0] addr, input logic [1:0] op, input logic [31:0] wdata, input int hold,
                          output logic [1:0] resp, output logic [31:0] data, output int lat,
                          output int pulses, output bit stable, output bit ready_low, output bit ready_after);
        int n;
        resp = '0; data = '0; lat = 0; pulses = 0; stable = 1; ready_low = 1; ready_after = 0;
        req_addr = addr; req_op = op; req_data = wdata; req_valid = 1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin
            $display("FAIL req_ready_timeout: req_ready=%0b required 1", req_ready);
            n_compared++; n_mismatched++; req_valid = 0; return;
        end
        @(posedge clk); #1 req_valid = 0;
        @(negedge clk); lat = 1;
        while (!resp_valid && lat < 60) begin
            if (resume_req) pulses++;
            @(negedge clk); lat++;
        end
        if (!resp_valid) begin
            $display("FAIL resp_valid_timeout: resp_valid=%0b required 1", resp_valid);
            n_compared++; n_mismatched++; return;
        end
        if (resume_req) pulses++;
        if (req_ready) ready_low = 0;
        resp = resp_bits; data = resp_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (resume_req) pulses++;
            if (req_ready) ready_low = 0;
            if (!resp_valid || resp_bits !== resp || resp_data !== data) stable = 0;
        end
        resp_ready = 1;
        @(posedge clk); #1 resp_ready = 0;
        @(negedge clk);
        if (resume_req) pulses++;
        ready_after = req_ready && !resp_valid;
    endtask

    task automatic pulse_resume_ack();
        hart_resume_ack = 1;
        @(negedge clk);
        hart_resume_ack = 0;
        m_resumeack = 1;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) @(negedge clk);
        n_compared++;
        if ({req_ready, resp_valid, resp_bits, resp_data, act0, hlt0, ndm0, resume_req} !== '0) begin
            $display("FAIL reset_outputs: got rdy=%0b rv=%0b resp=%0d data=%h act=%0b hlt=%0b ndm=%0b rsm=%0b required all 0",
                     req_ready, resp_valid, resp_bits, resp_data, act0, hlt0, ndm0, resume_req);
            n_mismatched++;
        end
        reset = 0;
        model_reset();
        #1;
        n_compared++;
        if (rdy0 !== 1'b1 || rdy3 !== 1'b1 || rv0 !== 1'b0) begin
            $display("FAIL post_reset_ready: got rdy0=%0b rdy3=%0b rv0=%0b required 1 1 0", rdy0, rdy3, rv0);
            n_mismatched++;
        end
        @(negedge clk);
    endtask

    task automatic test_data_rw();
        logic [1:0] r; logic [31:0] d; int lat, p; bit s, rl, ra;
        sel = 0;
        do_txn(7'h04, 2'd2, 32'hDEADBEEF, 0, r, d, lat, p, s, rl, ra);
        m_data[0] = 32'hDEADBEEF;
        n_compared++;
        if (r !== 2'd0 || d !== 32'd0 || lat != 2) begin
            $display("FAIL write_data0: got resp=%0d data=%h lat=%0d required 0 00000000 2", r, d, lat);
            n_mismatched++;
        end
        n_compared++;
        if (ra !== 1'b1) begin
            $display("FAIL ready_after_write: got %0b required 1", ra);
            n_mismatched++;
        end
        do_txn(7'h04, 2'd1, 32'h0, 0, r, d, lat, p, s, rl, ra);
        n_compared++;
        if (r !== 2'd0 || d !== 32'hDEADBEEF || lat != 2) begin
            $display("FAIL read_data0: got resp=%0d data=%h lat=%0d required 0 deadbeef 2", r, d, lat);
            n_mismatched++;
        end
    endtask

    task automatic test_latency_hold();
        logic [1:0] r; logic [31:0] d; int lat, p; bit s, rl, ra;
        sel = 1;
        do_txn(7'h16, 2'd1, 32'h0, 4, r, d, lat, p, s, rl, ra);
        n_compared++;
        if (r !== 2'd0 || d !== 32'h2 || lat != 5) begin
            $display("FAIL lat3_abstractcs: got resp=%0d data=%h lat=%0d required 0 00000002 5", r, d, lat);
            n_mismatched++;
        end
        n_compared++;
        if (s !== 1'b1 || rl !== 1'b1 || ra !== 1'b1) begin
            $display("FAIL lat3_hold: got stable=%0b ready_low=%0b ready_after=%0b required 1 1 1", s, rl, ra);
            n_mismatched++;
        end
        sel = 0;
    endtask

    task automatic test_resume();
        logic [1:0] r, er; logic [31:0] d, ed; int lat, p, ep; bit s, rl, ra;
        sel = 0; hart_halted = 0;
        model_txn(7'h10, 2'd2, 32'hC0000001, er, ed, ep);
        do_txn(7'h10, 2'd2, 32'hC0000001, 2, r, d, lat, p, s, rl, ra);
        n_compared++;
        if (r !== 2'd0 || hlt0 !== 1'b1 || act0 !== 1'b1 || p != 1) begin
            $display("FAIL resume_write: got resp=%0d halt_req=%0b dm_active=%0b pulses=%0d required 0 1 1 1",
                     r, hlt0, act0, p);
            n_mismatched++;
        end
        pulse_resume_ack();
        model_txn(7'h11, 2'd1, 32'h0, er, ed, ep);
        do_txn(7'h11, 2'd1, 32'h0, 0, r, d, lat, p, s, rl, ra);
        n_compared++;
        if (r !== 2'd0 || d !== 32'h00030C82) begin
            $display("FAIL dmstatus_resumeack: got resp=%0d data=%h required 0 00030c82", r, d);
            n_mismatched++;
        end
    endtask

    task automatic test_errors();
        logic [1:0] r, er; logic [31:0] d, ed; int lat, p, ep; bit s, rl, ra;
        sel = 0;
        do_txn(7'h7F, 2'd1, 32'h0, 0, r, d, lat, p, s, rl, ra);
        n_compared++;
        if (r !== 2'd2 || d !== 32'd0) begin
            $display("FAIL unmapped_read: got resp=%0d data=%h required 2 00000000", r, d);
            n_mismatched++;
        end
        do_txn(7'h04, 2'd3, 32'hFFFF0000, 0, r, d, lat, p, s, rl, ra);
        n_compared++;
        if (r !== 2'd2 || d !== 32'd0) begin
            $display("FAIL reserved_op: got resp=%0d data=%h required 2 00000000", r, d);
            n_mismatched++;
        end
        model_txn(7'h04, 2'd1, 32'h0, er, ed, ep);
        do_txn(7'h04, 2'd1, 32'h0, 0, r, d, lat, p, s, rl, ra);
        n_compared++;
        if (r !== er || d !== ed) begin
            $display("FAIL data0_after_errors: got resp=%0d data=%h required %0d %h", r, d, er, ed);
            n_mismatched++;
        end
    endtask

    task automatic test_dmactive_clear();
        logic [1:0] r, er; logic [31:0] d, ed; int lat, p, ep; bit s, rl, ra;
        sel = 0;
        model_txn(7'h04, 2'd2, 32'h12345678, er, ed, ep);
        do_txn(7'h04, 2'd2, 32'h12345678, 0, r, d, lat, p, s, rl, ra);
        model_txn(7'h10, 2'd2, 32'h80000001, er, ed, ep);
        do_txn(7'h10, 2'd2, 32'h80000001, 0, r, d, lat, p, s, rl, ra);
        n_compared++;
        if (hlt0 !== 1'b1) begin
            $display("FAIL haltreq_set: got %0b required 1", hlt0);
            n_mismatched++;
        end
        model_txn(7'h10, 2'd2, 32'h00000000, er, ed, ep);
        do_txn(7'h10, 2'd2, 32'h00000000, 0, r, d, lat, p, s, rl, ra);
        n_compared++;
        if (hlt0 !== 1'b0 || act0 !== 1'b0 || p != 0) begin
            $display("FAIL dmactive_clear: got halt_req=%0b dm_active=%0b pulses=%0d required 0 0 0", hlt0, act0, p);
            n_mismatched++;
        end
        do_txn(7'h04, 2'd1, 32'h0, 0, r, d, lat, p, s, rl, ra);
        n_compared++;
        if (r !== 2'd0 || d !== 32'd0) begin
            $display("FAIL data0_cleared: got resp=%0d data=%h required 0 00000000", r, d);
            n_mismatched++;
        end
    endtask

    task automatic test_random();
        logic [6:0] addr_tbl [7];
        logic [6:0] a; logic [1:0] op; logic [31:0] w;
        logic [1:0] r, er; logic [31:0] d, ed; int lat, p, ep; bit s, rl, ra;
        addr_tbl = '{7'h04, 7'h05, 7'h06, 7'h10, 7'h11, 7'h16, 7'h00};
        sel = 0;
        for (int t = 0; t < 60; t++) begin
            a  = addr_tbl[$urandom_range(0, 6)];
            if (a == 7'h00) a = 7'($urandom);
            op = 2'($urandom_range(0, 3));
            w  = $urandom;
            if (a == 7'h10 && $urandom_range(0, 3) != 0) w[0] = 1'b1;
            hart_halted = 1'($urandom);
            if ($urandom_range(0, 3) == 0) pulse_resume_ack();
            model_txn(a, op, w, er, ed, ep);
            do_txn(a, op, w, $urandom_range(0, 2), r, d, lat, p, s, rl, ra);
            n_compared++;
            if (r !== er || d !== ed || p != ep || lat != 2) begin
                $display("FAIL rand_txn[%0d] addr=%h op=%0d: got resp=%0d data=%h pulses=%0d lat=%0d required %0d %h %0d 2",
                         t, a, op, r, d, p, lat, er, ed, ep);
                n_mismatched++;
            end
            n_compared++;
            if (act0 !== m_dmactive || hlt0 !== m_haltreq || ndm0 !== m_ndmreset) begin
                $display("FAIL rand_mirror[%0d]: got act=%0b hlt=%0b ndm=%0b required %0b %0b %0b",
                         t, act0, hlt0, ndm0, m_dmactive, m_haltreq, m_ndmreset);
                n_mismatched++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int n, seen;
        sel = 0;
        req_addr = 7'h16; req_op = 2'd1; req_data = '0; req_valid = 1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 req_valid = 0;
        n = 0;
        while (!resp_valid && n < 50) begin @(negedge clk); n++; end
        reset = 1;
        #1;
        n_compared++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            $display("FAIL reset_in_resp: got resp_valid=%0b req_ready=%0b required 0 0", resp_valid, req_ready);
            n_mismatched++;
        end
        repeat (2) @(negedge clk);
        reset = 0;
        model_reset();
        #1;
        n_compared++;
        if (req_ready !== 1'b1) begin
            $display("FAIL ready_after_reset: got %0b required 1", req_ready);
            n_mismatched++;
        end
        resp_ready = 1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        resp_ready = 0;
        n_compared++;
        if (seen != 0) begin
            $display("FAIL stale_response: got %0d resp_valid cycles required 0", seen);
            n_mismatched++;
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_data_rw();
        test_latency_hold();
        test_resume();
        test_errors();
        test_dmactive_clear();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmi_responder.md
Name: dmi_responder

Overview:
Synthesizable target end of the debug module interface (DMI) request/response channel. Accepts DMI requests (addr/op/data) from a DTM initiator, performs the access on a small debug-module register set, and returns one response per request. Sits between the DTM and the hart's halt/resume controls.

Parameters:
NDATA, 2, number of abstract data registers data0..data(NDATA-1); legal range 1..12
ACCESS_LATENCY, 0, extra wait cycles between request accept and register access; legal range 0..15

Ports:
clk  in  1  clock
reset  in  1  reset
debug_req_valid  in  1  request valid
debug_req_ready  out  1  responder can accept a request
debug_req_bits_addr  in  7  register address
debug_req_bits_op  in  2  0=nop, 1=read, 2=write, 3=reserved
debug_req_bits_data  in  32  write data
debug_resp_valid  out  1  response valid
debug_resp_ready  in  1  initiator accepts response
debug_resp_bits_resp  out  2  0=success, 2=failed
debug_resp_bits_data  out  32  read data
hart_halted  in  1  hart halted status
hart_resume_ack  in  1  one-cycle pulse: hart has resumed
dm_active  out  1  dmcontrol.dmactive
halt_req  out  1  dmcontrol.haltreq
ndm_reset  out  1  dmcontrol.ndmreset
resume_req  out  1  one-cycle resume pulse

Behaviour:
- One clock. Reset is synchronous and active-high. Port names are clk and reset.
- Reset behaviour: while reset is high, all outputs are 0 and debug_req_ready is forced to 0. At the reset edge, the FSM goes to IDLE, all registers clear, and resumeack clears.
- FSM states:
  - IDLE: req_ready=1. On valid&&ready, capture addr/op/data. Go to ACCESS if ACCESS_LATENCY>0, otherwise go to EXEC.
  - ACCESS: count down ACCESS_LATENCY cycles, then go to EXEC. req_ready=0.
  - EXEC: single cycle. Decode, apply write side effects, and register resp/data. Go to RESP.
  - RESP: resp_valid=1. resp/data stay stable until resp_ready. On handshake go to IDLE.
- Latency: accept edge to resp_valid high is 2+ACCESS_LATENCY cycles. req_ready is not re-asserted in the same cycle as the response handshake. Exactly one request is outstanding at a time.
- Register map:
  - 0x04+i (i<NDATA), data_i: RW.
  - 0x10, dmcontrol:
    - bit0 dmactive: RW.
    - bit1 ndmreset: RW.
    - bit31 haltreq: RW.
    - bit30 resumereq: write-1 pulse, reads 0.
  - 0x11, dmstatus (RO):
    - [3:0]=2
    - bit7=1
    - bits9:8 = {2{hart_halted}}
    - bits11:10 = {2{dm_active & ~hart_halted}}
    - bits17:16 = {2{resumeack}}
  - 0x16, abstractcs (RO): [3:0]=NDATA, other bits 0.
- Response and write rules:
  - Write to an RO register: ignored, resp=0.
  - Unmapped address (read or write): resp=2, data=0.
  - op=0: resp=0, data=0, no side effects.
  - op=3: resp=2, data=0.
  - Write response data is 0.
- dmcontrol write with dmactive=0: clears all data_i, haltreq, ndmreset and resumeack. No resume pulse. Other written fields are ignored.
- dmcontrol write with dmactive=1 and bit30=1: resume_req pulses high for exactly the cycle after EXEC, and resumeack clears in EXEC.
- hart_resume_ack sets resumeack sticky, except in a cycle where EXEC clears it (clear wins).
- Output mirrors: dm_active, halt_req and ndm_reset are registered copies of the dmcontrol bits.
- Reset mid-transaction (ACCESS/EXEC/RESP): the transaction is dropped, no response is issued, and pending write effects are discarded.
- debug_req_valid while not ready: ignored. No buffering; the initiator must hold the request.

Decomposition:
- Shared package dmi_pkg:
  - op codes (DMI_OP_NOP/READ/WRITE)
  - resp codes (DMI_RESP_OK=0, DMI_RESP_FAIL=2)
  - register addresses (DATA0=0x04, DMCONTROL=0x10, DMSTATUS=0x11, ABSTRACTCS=0x16)
  - dmcontrol bit indices
  - FSM state enum
- One sub-module, dmi_regfile: register storage, address decode, side effects and resumeack. It is driven by an exec strobe from the handshake FSM in dmi_responder.

Test Plan:
- Write data0=0xDEADBEEF (addr 0x04, op 2) then read 0x04 -> first resp=0 data=0; second resp=0 data=0xDEADBEEF; resp_valid rises 2 cycles after each accept edge.
- ACCESS_LATENCY=3, read 0x16 with NDATA=2 -> resp_valid 5 cycles after accept, data=0x00000002; hold resp_ready=0 for 4 cycles -> resp/data stable, req_ready stays 0.
- Write dmcontrol 0xC0000001 -> halt_req=1, dm_active=1, resume_req high exactly one cycle; then pulse hart_resume_ack with hart_halted=0 -> read 0x11 returns 0x00030C82.
- Read 0x7F and request op=3 at 0x04 -> both resp=2 data=0; data0 unchanged on readback.
- Write dmcontrol 0x00000000 after data0=0x12345678 and haltreq=1 -> halt_req=0, data0 reads 0.
- Assert reset during RESP of a pending read -> resp_valid drops, no response after reset, req_ready=1 the cycle after reset deasserts.
